module_operand_entry: RTL and testbench

- Producer side of the operand-load handshake: collects decimal digits from the keypad decoder and accumulates them into a binary operand.
- On the enter key it presents the operand and raises rdy, holding it until the operand-load sequencer acknowledges with ack.
- Sits between the keypad scan/decode logic and the operand sequencer. The sequencer loads operand A, then operand B, then result, advancing on each rdy.

---
 rtl/operand_pkg.sv | 19 +
 rtl/module_dec_accum.sv | 27 ++
 rtl/module_operand_entry.sv | 118 +++++++++++
 tb/tb_module_operand_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared definitions for the operand-entry block: keypad codes and the
// entry FSM state encoding.
package operand_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } entry_state_t;

    // Digit keys are 0x0..0x9; everything above that is a command or unused.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'h9);
    endfunction

endpackage

// File: rtl/module_dec_accum.sv
// Decimal accumulate step: next_acc = acc*10 + digit.
// Ports:
//   acc      in  WIDTH  current accumulator value
//   digit    in  4      decimal digit 0..9
//   next_acc out WIDTH  acc*10 + digit, truncated to WIDTH
//   ovf      out 1      set if the full-width result does not fit in WIDTH
module module_dec_accum #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] next_acc,
    output logic             ovf
);

    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] sum;

    always_comb begin
        acc_ext  = {4'b0000, acc};
        // x*10 as x*8 + x*2, evaluated 4 bits wider so nothing is lost
        sum      = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
        next_acc = sum[WIDTH-1:0];
        ovf      = |sum[WIDTH+3:WIDTH];
    end

endmodule

// File: rtl/module_operand_entry.sv
// Operand entry: accumulates keypad digits into a binary operand and offers
// it to the operand-load sequencer with a rdy/ack handshake.
// Ports:
//   clk          in   1      system clock
//   rst          in   1      synchronous, active-low reset
//   key_valid    in   1      key_code valid strobe
//   key_code     in   4      0-9 digit, 0xA enter, 0xC clear, others ignored
//   ack          in   1      consumer load strobe; honoured only in HOLD
//   rdy          out  1      operand valid, held until ack
//   operand      out  WIDTH  last committed operand
//   digit_count  out  CW     digits in the accumulator
//   entering     out  1      accumulator holds uncommitted digits
module module_operand_entry
    import operand_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    input  logic                        ack,
    output logic                        rdy,
    output logic [WIDTH-1:0]            operand,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic                        entering
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    entry_state_t     state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] operand_q, operand_d;

    logic [WIDTH-1:0] acc_next;
    logic             acc_ovf;
    logic             key_digit;

    // In IDLE the accumulator is zero, so the same step yields just the digit.
    module_dec_accum #(
        .WIDTH (WIDTH)
    ) u_dec_accum (
        .acc      (acc_q),
        .digit    (key_code),
        .next_acc (acc_next),
        .ovf      (acc_ovf)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        key_digit = key_valid && is_digit(key_code);

        unique case (state_q)
            IDLE: begin
                if (key_digit) begin
                    acc_d   = acc_next;
                    cnt_d   = CW'(1);
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (key_digit) begin
                    // Extra digits beyond DIGITS are dropped, not saturated
                    if (cnt_q < MAX_CNT && !acc_ovf) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (key_valid && key_code == KEY_CLEAR) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (key_valid && key_code == KEY_ENTER) begin
                    operand_d = acc_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // Keys are dropped here, including one coincident with ack
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
        end
    end

    assign rdy         = (state_q == HOLD);
    assign entering    = (state_q == ENTRY);
    assign operand     = operand_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_module_operand_entry.sv
module tb_module_operand_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       ack;
    logic       rdy;
    logic [9:0] operand;
    logic [1:0] digit_count;
    logic       entering;

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;

    module_operand_entry #(
        .DIGITS (3),
        .WIDTH  (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .ack         (ack),
        .rdy         (rdy),
        .operand     (operand),
        .digit_count (digit_count),
        .entering    (entering)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes the DUT actually completes
    always @(posedge clk) begin
        if (rst && ack && rdy) n_acks++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Sequencer load: wait (bounded) for rdy, strobe ack, capture operand
    task automatic seq_load(input string tag, output int val);
        int waited = 0;
        val = -1;
        while (!rdy && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_rdy_seen"}, int'(rdy), 1);
        if (rdy) begin
            val = int'(operand);
            do_ack();
        end
    endtask

    int a_val, b_val;

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        ack       = 1'b0;
        step();
        step();
        check("rst_rdy", int'(rdy), 0);
        check("rst_operand", int'(operand), 0);
        check("rst_count", int'(digit_count), 0);
        check("rst_entering", int'(entering), 0);
        rst = 1'b1;

        // Reset mid-entry
        press(4'd4);
        press(4'd2);
        check("mid_entering", int'(entering), 1);
        check("mid_count", int'(digit_count), 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_rdy", int'(rdy), 0);
        check("midrst_operand", int'(operand), 0);
        check("midrst_count", int'(digit_count), 0);
        check("midrst_entering", int'(entering), 0);

        // 1,2,3 enter, ack two cycles later
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check("123_count", int'(digit_count), 3);
        press(4'hA);
        check("123_rdy1", int'(rdy), 1);
        check("123_op1", int'(operand), 123);
        check("123_count0", int'(digit_count), 0);
        check("123_entering0", int'(entering), 0);
        step();
        check("123_rdy2", int'(rdy), 1);
        ack = 1'b1;
        check("123_rdy_ackcyc", int'(rdy), 1);
        check("123_op_ackcyc", int'(operand), 123);
        step();
        ack = 1'b0;
        check("123_rdy_after", int'(rdy), 0);
        check("123_op_after", int'(operand), 123);

        // 9,9,9,7: fourth digit dropped
        press(4'd9);
        press(4'd9);
        press(4'd9);
        press(4'd7);
        check("999_count", int'(digit_count), 3);
        press(4'hA);
        check("999_op", int'(operand), 999);
        check("999_rdy", int'(rdy), 1);
        do_ack();

        // 5, clear, 8, enter
        press(4'd5);
        press(4'hC);
        check("clr_count", int'(digit_count), 0);
        check("clr_entering", int'(entering), 0);
        check("clr_op_kept", int'(operand), 999);
        press(4'd8);
        press(4'hA);
        check("8_op", int'(operand), 8);
        do_ack();

        // Enter, clear, ack and an unused code in IDLE do nothing
        press(4'hA);
        check("idle_enter_rdy", int'(rdy), 0);
        check("idle_enter_op", int'(operand), 8);
        press(4'hC);
        press(4'hF);
        do_ack();
        check("idle_misc_rdy", int'(rdy), 0);
        check("idle_misc_entering", int'(entering), 0);

        // HOLD with 42: keys ignored; key with simultaneous ack dropped
        press(4'd4);
        press(4'd2);
        press(4'hA);
        check("42_op", int'(operand), 42);
        press(4'd5);
        check("hold_key_rdy", int'(rdy), 1);
        check("hold_key_count", int'(digit_count), 0);
        check("hold_key_op", int'(operand), 42);
        key_valid = 1'b1;
        key_code  = 4'd7;
        ack       = 1'b1;
        step();
        key_valid = 1'b0;
        ack       = 1'b0;
        check("hold_ack_rdy", int'(rdy), 0);
        check("hold_ack_entering", int'(entering), 0);
        check("hold_ack_count", int'(digit_count), 0);
        press(4'd6);
        press(4'hA);
        check("6_op", int'(operand), 6);
        do_ack();

        // Two-operand sequence against a sequencer model
        n_acks = 0;
        press(4'd1);
        press(4'd2);
        press(4'hA);
        seq_load("A", a_val);
        press(4'd3);
        press(4'd4);
        press(4'hA);
        seq_load("B", b_val);
        step();
        check("seq_A", a_val, 12);
        check("seq_B", b_val, 34);
        check("seq_acks", n_acks, 2);
        check("seq_rdy_idle", int'(rdy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
